// File: rtl/oven_cook_timer.sv
// Elapsed-cook-time generator: counts heated time units toward a latched target,
// with pause/resume on start edges and clear on stop.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | cleared, waiting for a start edge with a non-zero set_time
// S_RUN   | prescaler advances while horno is high
// S_PAUSE | all counts frozen; the next start edge resumes
// S_DONE  | current_time == target, time_done asserted
module oven_cook_timer #(
   parameter int unsigned TICK_DIV = 25_000_000,
   parameter int unsigned DIV_W    = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       horno,
   input  logic [3:0] set_time,
   output logic [3:0] current_time,
   output logic       tick,
   output logic       time_done,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(TICK_DIV - 1);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] prescale_q, prescale_d;
   logic [3:0]       target_q, target_d;
   logic [3:0]       time_q, time_d;
   logic             tick_q, tick_d;
   logic             start_q;
   logic             start_rise;
   logic [3:0]       time_inc;

   assign start_rise = start & ~start_q;
   assign time_inc   = time_q + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         prescale_q <= '0;
         target_q   <= '0;
         time_q     <= '0;
         tick_q     <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         prescale_q <= prescale_d;
         target_q   <= target_d;
         time_q     <= time_d;
         tick_q     <= tick_d;
         start_q    <= start;
      end
   end

   always_comb begin
      state_d    = state_q;
      prescale_d = prescale_q;
      target_d   = target_q;
      time_d     = time_q;
      tick_d     = 1'b0;

      // stop wins over any command, including a start edge in the same cycle
      if (stop) begin
         state_d    = S_IDLE;
         prescale_d = '0;
         target_d   = '0;
         time_d     = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start_rise && (set_time != 4'd0)) begin
                  target_d   = set_time;
                  time_d     = '0;
                  prescale_d = '0;
                  state_d    = S_RUN;
               end
            end
            S_RUN: begin
               if (start_rise) begin
                  state_d = S_PAUSE;
               end else if (horno) begin
                  if (prescale_q < PRE_LAST) begin
                     prescale_d = prescale_q + 1'b1;
                  end else begin
                     prescale_d = '0;
                     time_d     = time_inc;
                     tick_d     = 1'b1;
                     if (time_inc == target_q) state_d = S_DONE;
                  end
               end
            end
            S_PAUSE: begin
               if (start_rise) state_d = S_RUN;
            end
            S_DONE: begin
               if (start_rise) begin
                  prescale_d = '0;
                  time_d     = '0;
                  if (set_time != 4'd0) begin
                     target_d = set_time;
                     state_d  = S_RUN;
                  end else begin
                     state_d  = S_IDLE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      current_time = time_q;
      tick         = tick_q;
      time_done    = (state_q == S_DONE);
      busy         = (state_q == S_RUN) || (state_q == S_PAUSE);
   end

endmodule
